// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flagged sync FIFO: occupancy arithmetic and threshold range checks.
// Purely combinational; no state.
package sync_fifo_pkg;

    // Modulo 2**ptr_w difference of the extended pointers gives occupancy, wrap included.
    function automatic logic [31:0] fifo_level(input logic [31:0] wr_ptr,
                                               input logic [31:0] rd_ptr,
                                               input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (ptr_w >= 32) ? '1 : ((32'd1 << ptr_w) - 32'd1);
        return (wr_ptr - rd_ptr) & mask;
    endfunction

    function automatic bit af_level_ok(input int unsigned depth, input int unsigned af);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_level_ok(input int unsigned depth, input int unsigned ae);
        return ae <= (depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read (distributed RAM).
// Zero-latency read; no flow control of its own, contents are never reset.
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with registered read port (1-cycle latency), level and threshold flags.
// Back-pressure is flag based: rejected writes/reads set sticky overflow/underflow.
module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    if (!af_level_ok(DEPTH, AF_LEVEL)) begin : g_bad_af_level
        $error("sync_fifo_flagged: AF_LEVEL out of range 1..DEPTH");
    end
    if (!ae_level_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae_level
        $error("sync_fifo_flagged: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] head;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  ram_we;
    logic                  ov_evt;
    logic                  uf_evt;

    // Every flag decodes from the registered pointers only.
    assign level        = PTR_W'(fifo_level(32'(wr_ptr), 32'(rd_ptr), PTR_W));
    assign empty        = (level == '0);
    assign full         = (level == PTR_W'(DEPTH));
    assign almost_full  = (level >= PTR_W'(AF_LEVEL));
    assign almost_empty = (level <= PTR_W'(AE_LEVEL));

    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);
    assign ram_we    = wr_accept && !flush;

    // Flush drops requests silently, so it also masks the error events.
    assign ov_evt = !flush && wr_en && !wr_accept;
    assign uf_evt = !flush && rd_en && !rd_accept;

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= head;
            end
            rd_valid <= rd_accept;
        end
    end

    // An error event in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow && !clr_err) || ov_evt;
            underflow <= (underflow && !clr_err) || uf_evt;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_sync_fifo_flagged;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          clr_err;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    sync_fifo_flagged #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .clr_err      (clr_err),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue of stored entries plus the observable registers.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dat;
    logic          m_vld;
    logic          m_ov;
    logic          m_uf;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("rd_data",      32'(rd_data),      32'(m_dat));
        chk("rd_valid",     32'(rd_valid),     32'(m_vld));
        chk("level",        32'(level),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow",     32'(overflow),     32'(m_ov));
        chk("underflow",    32'(underflow),    32'(m_uf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dat = '0;
        m_vld = 1'b0;
        m_ov  = 1'b0;
        m_uf  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model from pre-edge state, check after the edge.
    task automatic step(input logic fl, input logic ce, input logic we,
                        input logic [DW-1:0] wd, input logic re);
        int  n;
        bit  rda;
        bit  wra;
        flush   = fl;
        clr_err = ce;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        n   = q.size();
        rda = re && (n != 0);
        wra = we && ((n != DEPTH) || rda);
        m_ov = (m_ov && !ce) || (!fl && we && !wra);
        m_uf = (m_uf && !ce) || (!fl && re && !rda);
        if (fl) begin
            q.delete();
            m_vld = 1'b0;
        end else begin
            if (rda) begin
                m_dat = q.pop_front();
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            if (wra) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        check_all();
        flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        step(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Fill then drain in order.
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        chk("full_after_4", 32'(full), 32'd1);
        repeat (4) rd();
        chk("last_read", 32'(rd_data), 32'h44);

        // Overflow on full, then simultaneous read/write while full.
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        wr(8'h55);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
        chk("rw_full_data", 32'(rd_data), 32'h11);
        repeat (4) rd();
        chk("rw_full_tail", 32'(rd_data), 32'h66);

        // Read while empty with a concurrent write: no bypass.
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        chk("udf_set", 32'(underflow), 32'd1);
        rd();
        chk("after_udf_read", 32'(rd_data), 32'h77);

        // Flush overrides a simultaneous read and write.
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        step(1'b1, 1'b0, 1'b1, 8'hA4, 1'b1);
        chk("flush_level", 32'(level), 32'd0);

        // Sticky overflow clearing and clear-vs-event priority.
        wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4); wr(8'hB5);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 1'b1, 8'hB6, 1'b0);
        chk("ovf_event_wins", 32'(overflow), 32'd1);

        // Asynchronous reset mid-operation.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        wr(8'hC1); wr(8'hC2); wr(8'hC3); rd();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous streaming across pointer wrap.
        wr(8'hD0);
        for (int i = 1; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hD0 + i), 1'b1);
        rd();
        chk("stream_last", 32'(rd_data), 32'hD9);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
